pe_drain: RTL and testbench
===========================

# pe_drain

Downstream collector for one row of the systolic PE array. It captures the `out_data`/`out_valid` result stream leaving the last PE of a row and buffers it in a small FIFO. It re-emits the results as an AXI4-Stream master with `tlast` framing every N results. The PE chain cannot be stalled, so the block absorbs bursts and flags any loss instead of back-pressuring.

## Interface

- `D_W_ACC`, 64: result (accumulator) data width; matches the PE accumulator width.
- `N`, 8: results per row burst; `m_axis_tlast` marks every N-th emitted beat; N ≥ 1.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2; must be ≥ N for loss-free operation.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state immediately.
- `in_data`  in  D_W_ACC  result word from the last PE of the row.
- `in_valid`  in  1  `in_data` is a valid result this cycle; no ready is returned.
- `m_axis_tdata`  out  D_W_ACC  head-of-FIFO result.
- `m_axis_tvalid`  out  1  FIFO non-empty.
- `m_axis_tready`  in  1  downstream accepts the beat.
- `m_axis_tlast`  out  1  current beat is the N-th of its frame.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when a valid input was dropped.

## Operation

- Storage: DEPTH-entry memory, write pointer `wr_ptr` and read pointer `rd_ptr` (log2 DEPTH bits each, natural wrap), plus occupancy register `count`.
- Push: `push = in_valid && (count < DEPTH || pop)`. On push, `in_data` is written at `wr_ptr` and `wr_ptr` increments.
- Pop: `pop = m_axis_tvalid && m_axis_tready`. On pop, `rd_ptr` increments.
- Count update: `count` += push − pop. Simultaneous push and pop leaves `count` unchanged. This holds when full: the popped slot is reused and nothing is dropped.
- Drop: `in_valid && count == DEPTH && !pop`. The word is discarded, `overflow` is set to 1, and `overflow` holds until reset.
- Output:
  - `m_axis_tvalid = (count != 0)`.
  - `m_axis_tdata = mem[rd_ptr]` when `tvalid`, else 0.
  - `tdata` and `tlast` hold stable while `tvalid && !tready`.
- Framing:
  - Beat counter `beat`, 0..N-1, increments on each pop and wraps from N-1 to 0.
  - `m_axis_tlast = m_axis_tvalid && (beat == N-1)`.
  - With N = 1, `tlast` is asserted on every valid beat.
- Dropped inputs do not advance `beat`; framing counts emitted beats only.
- Values are passed through unmodified; no width change or arithmetic on data.

## Timing

- Reset values:
  - `count` = 0; `wr_ptr` = `rd_ptr` = 0; `beat` = 0.
  - `overflow` = 0, `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0.
  - Memory contents are not reset.
- Latency: an input valid in cycle t (sampled at edge t) appears on `m_axis_tvalid`/`tdata` in cycle t+1. There is no combinational bypass from `in_*` to `m_axis_*`.
- Throughput: one push and one pop per cycle sustained; a full FIFO with `tready` high loses nothing.
- `m_axis_tvalid` never deasserts without a pop. AXI rule: no dependency of `tvalid` on `tready` within a cycle.
- Empty FIFO plus input in the same cycle: no pop that cycle; the word is visible next cycle.
- Reset asserted mid-burst:
  - All outputs drop to reset values asynchronously.
  - Buffered data is discarded and `beat` restarts at 0 after release.
  - Inputs are ignored while `rst` is high.

## Test plan

- Reset/idle: assert `rst` mid-cycle with 3 words buffered → `tvalid`, `tlast`, `tdata`, `count`, `overflow` all 0 immediately; after release with `tready`=1 and no input, the outputs stay 0.
- Streaming, N=8: 16 consecutive valid inputs 1..16 with `tready`=1 →
  - outputs 1..16 in order, each one cycle after its input;
  - `tlast` on values 8 and 16;
  - `count` ≤ 1; `overflow` stays 0.
- Backpressure fill, DEPTH=16: `tready`=0, 16 inputs → `count`=16, `tvalid`=1, `tdata`=first word, stable. A 17th input → dropped, `overflow`=1. Then `tready`=1 → exactly 16 words drain in order with `tlast` on beats 8 and 16; `overflow` remains 1.
- Full plus simultaneous push/pop: FIFO at 16, `tready`=1 with continued input for 20 cycles → no drop, `count` stays 16, `overflow` stays 0, order preserved.
- Stall mid-frame: toggle `tready` pseudo-randomly over 3 frames of N=8 with bursty input → no loss, no duplication, `tdata`/`tlast` stable during stalls, `tlast` exactly on beats 8, 16, 24.

Source files
------------

// File: rtl/pe_drain.sv
// pe_drain: collector for the result stream leaving the last PE of a row.
// Results are buffered in a small FIFO and re-emitted as an AXI4-Stream
// master, with tlast marking every N-th emitted beat. The PE chain cannot
// be stalled, so a word that arrives while the FIFO is full and not
// draining is dropped, and a sticky overflow flag records the loss.
module pe_drain #(
  parameter int D_W_ACC = 64,
  parameter int N       = 8,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [D_W_ACC-1:0]       in_data,
  input  logic                     in_valid,
  output logic [D_W_ACC-1:0]       m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(N - 1);

  logic [D_W_ACC-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          overflow_q, overflow_d;

  logic push;
  logic pop;
  logic drop;
  logic full;

  // Handshake decode; a pop frees a slot in the same cycle, so a full FIFO
  // that is draining still accepts the incoming word.
  always_comb begin
    full = (count_q == FULL_COUNT);
    pop  = m_axis_tvalid && m_axis_tready;
    push = in_valid && (!full || pop);
    drop = in_valid && full && !pop;
  end

  // Next-state for pointers, occupancy, frame position and the loss flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_d     = beat_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (beat_q == LAST_BEAT) begin
        beat_d = '0;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Storage array; contents are never reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Control state with asynchronous clear, discarding any buffered words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs depend only on registered state, so tvalid never looks at tready
  // and tdata/tlast stay put while a beat is stalled.
  always_comb begin
    m_axis_tvalid = (count_q != '0);
    m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
    m_axis_tlast  = m_axis_tvalid && (beat_q == LAST_BEAT);
    count         = count_q;
    overflow      = overflow_q;
  end

endmodule

// File: tb/tb_pe_drain.sv
// tb_pe_drain: randomized and directed stimulus for pe_drain, checked
// every cycle against a queue-based reference model of the FIFO.
module tb_pe_drain;

  localparam int DW    = 64;
  localparam int N     = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [CW-1:0] count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] refQ[$];
  int            refBeat = 0;
  bit            refOvf  = 1'b0;

  pe_drain #(.D_W_ACC(DW), .N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .count        (count),
    .overflow     (overflow)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
    end
  endtask

  task automatic compareAll();
    bit            expValid;
    logic [DW-1:0] expData;
    bit            expLast;
    expValid = (refQ.size() != 0);
    expData  = expValid ? refQ[0] : '0;
    expLast  = expValid && (refBeat == N - 1);
    checkOutput("tvalid",   DW'(m_axis_tvalid), DW'(expValid));
    checkOutput("tdata",    m_axis_tdata,       expData);
    checkOutput("tlast",    DW'(m_axis_tlast),  DW'(expLast));
    checkOutput("count",    DW'(count),         DW'(refQ.size()));
    checkOutput("overflow", DW'(overflow),      DW'(refOvf));
  endtask

  task automatic checkAllZero(input string phase);
    checkOutput({phase, "_tvalid"},   DW'(m_axis_tvalid), '0);
    checkOutput({phase, "_tlast"},    DW'(m_axis_tlast),  '0);
    checkOutput({phase, "_tdata"},    m_axis_tdata,       '0);
    checkOutput({phase, "_count"},    DW'(count),         '0);
    checkOutput({phase, "_overflow"}, DW'(overflow),      '0);
  endtask

  // Reference behaviour for one clock edge: the head leaves if the
  // consumer is ready, and an arriving word is kept if a slot is free
  // after that departure, otherwise it is lost.
  task automatic modelStep(input logic v, input logic [DW-1:0] d, input logic r);
    bit wasFull;
    bit popped;
    wasFull = (refQ.size() == DEPTH);
    popped  = (refQ.size() != 0) && r;
    if (popped) begin
      void'(refQ.pop_front());
      refBeat = (refBeat + 1) % N;
    end
    if (v) begin
      if (!wasFull || popped) refQ.push_back(d);
      else refOvf = 1'b1;
    end
  endtask

  // One cycle: drive inputs just after the edge, check mid-cycle, then
  // advance the model across the next rising edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid      = v;
    in_data       = d;
    m_axis_tready = r;
    @(negedge clk);
    compareAll();
    @(posedge clk);
    modelStep(v, d, r);
    #1;
  endtask

  // Assert reset in the middle of a cycle and expect outputs to clear at once.
  task automatic resetMidCycle();
    #2;
    in_valid = 1'b1;
    in_data  = DW'(64'h0BAD_0BAD);
    rst      = 1'b1;
    #1;
    checkAllZero("rst_async");
    refQ.delete();
    refBeat = 0;
    refOvf  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_data       = '0;
    m_axis_tready = 1'b0;
    #1;
    checkAllZero("rst_init");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming: each word appears one cycle after it arrives.
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, DW'(i), 1'b1);
    repeat (3) applyStimulus(1'b0, '0, 1'b1);

    // Three words buffered, then reset mid-cycle; idle afterwards.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(32'hA0 + i), 1'b0);
    resetMidCycle();
    repeat (4) applyStimulus(1'b0, '0, 1'b1);

    // Backpressure fill, one dropped word, then full drain.
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, DW'(32'h100 + i), 1'b0);
    applyStimulus(1'b1, DW'(32'hDEAD), 1'b0);
    repeat (18) applyStimulus(1'b0, '0, 1'b1);

    // Full FIFO with simultaneous push and pop loses nothing.
    resetMidCycle();
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, DW'(32'h200 + i), 1'b0);
    for (int i = 1; i <= 20; i++) applyStimulus(1'b1, DW'(32'h300 + i), 1'b1);
    repeat (18) applyStimulus(1'b0, '0, 1'b1);

    // Random stalls with bursty input, then drain.
    resetMidCycle();
    for (int i = 0; i < 400; i++) begin
      logic          v;
      logic          r;
      logic [DW-1:0] d;
      v = ((i / 12) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 2) != 0);
      d = {$urandom, $urandom};
      applyStimulus(v, d, r);
    end
    repeat (DEPTH + 2) applyStimulus(1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
